// File: rtl/demux_stream_buffered_pkg.sv
// demux_stream_buffered_pkg: lane IDs and default sizing shared by the demux stream buffer
package demux_stream_buffered_pkg;
    localparam logic LANE1 = 1'b0;
    localparam logic LANE2 = 1'b1;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 2;
endpackage

// File: rtl/demux_lane_fifo.sv
// demux_lane_fifo: per-lane FIFO with registered storage and combinational head
module demux_lane_fifo
    import demux_stream_buffered_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];
    // Storage, pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/demux_stream_buffered.sv
// demux_stream_buffered: steers one stream into two buffered lanes; DEMUX_STATS_EN adds STALL_CNT
module demux_stream_buffered
    import demux_stream_buffered_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT1_DATA,
    output logic             OUT1_VALID,
    input  logic             OUT1_READY,
    output logic [WIDTH-1:0] OUT2_DATA,
    output logic             OUT2_VALID,
    input  logic             OUT2_READY
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      STALL_CNT
`endif
);
    logic full1, full2, empty1, empty2;
    logic push1, push2;
    assign IN_READY = (IN_SELECT == LANE2) ? !full2 : !full1;
    assign push1 = IN_VALID && IN_READY && (IN_SELECT == LANE1);
    assign push2 = IN_VALID && IN_READY && (IN_SELECT == LANE2);
    assign OUT1_VALID = !empty1;
    assign OUT2_VALID = !empty2;

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .clk(CLK), .rst(RESET), .push(push1), .push_data(IN_DATA), .pop(OUT1_READY),
        .full(full1), .empty(empty1), .head(OUT1_DATA)
    );

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane2 (
        .clk(CLK), .rst(RESET), .push(push2), .push_data(IN_DATA), .pop(OUT2_READY),
        .full(full2), .empty(empty2), .head(OUT2_DATA)
    );

`ifdef DEMUX_STATS_EN
    // Saturating count of cycles the producer offers a word that is refused
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) STALL_CNT <= '0;
        else if (IN_VALID && !IN_READY && STALL_CNT != 16'hFFFF) STALL_CNT <= STALL_CNT + 16'd1;
    end
`endif
endmodule

// File: tb/tb_demux_stream_buffered.sv
// tb_demux_stream_buffered: directed self-checking bench for demux_stream_buffered
module tb_demux_stream_buffered;
    logic       CLK = 0;
    logic       RESET = 1;
    logic [7:0] IN_DATA = '0;
    logic       IN_SELECT = 0;
    logic       IN_VALID = 0;
    logic       IN_READY;
    logic [7:0] OUT1_DATA, OUT2_DATA;
    logic       OUT1_VALID, OUT2_VALID;
    logic       OUT1_READY = 0;
    logic       OUT2_READY = 0;
`ifdef DEMUX_STATS_EN
    logic [15:0] STALL_CNT;
`endif
    int n_checks = 0;
    int n_fails = 0;

    demux_stream_buffered dut (
        .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_SELECT(IN_SELECT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT1_DATA(OUT1_DATA), .OUT1_VALID(OUT1_VALID), .OUT1_READY(OUT1_READY),
        .OUT2_DATA(OUT2_DATA), .OUT2_VALID(OUT2_VALID), .OUT2_READY(OUT2_READY)
`ifdef DEMUX_STATS_EN
        , .STALL_CNT(STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12;
        check("rst_v1", 16'(OUT1_VALID), 16'h0);
        check("rst_v2", 16'(OUT2_VALID), 16'h0);
        check("rst_d1", 16'(OUT1_DATA), 16'h00);
        check("rst_d2", 16'(OUT2_DATA), 16'h00);
        @(negedge CLK);
        RESET = 0;
        #1;
        check("idle_rdy_sel0", 16'(IN_READY), 16'h1);
        IN_SELECT = 1;
        #1;
        check("idle_rdy_sel1", 16'(IN_READY), 16'h1);
        check("idle_v1", 16'(OUT1_VALID), 16'h0);

        // single words to each lane, consumers ready
        OUT1_READY = 1; OUT2_READY = 1;
        IN_VALID = 1; IN_SELECT = 0; IN_DATA = 8'hA5;
        tick();
        check("a5_v1", 16'(OUT1_VALID), 16'h1);
        check("a5_d1", 16'(OUT1_DATA), 16'hA5);
        IN_SELECT = 1; IN_DATA = 8'h3C;
        tick();
        check("a5_gone", 16'(OUT1_VALID), 16'h0);
        check("3c_v2", 16'(OUT2_VALID), 16'h1);
        check("3c_d2", 16'(OUT2_DATA), 16'h3C);
        IN_VALID = 0;
        tick();
        check("3c_gone", 16'(OUT2_VALID), 16'h0);

        // fill lane 1 while lane 2 keeps flowing
        OUT1_READY = 0;
        IN_VALID = 1; IN_SELECT = 0; IN_DATA = 8'h01;
        tick();
        IN_DATA = 8'h02;
        tick();
        IN_DATA = 8'h03;
        #1;
        check("full1_rdy", 16'(IN_READY), 16'h0);
        check("full1_head", 16'(OUT1_DATA), 16'h01);
        IN_SELECT = 1; IN_DATA = 8'h04;
        #1;
        check("other_rdy", 16'(IN_READY), 16'h1);
        tick();
        check("04_v2", 16'(OUT2_VALID), 16'h1);
        check("04_d2", 16'(OUT2_DATA), 16'h04);
        check("held_v1", 16'(OUT1_VALID), 16'h1);
        IN_VALID = 0; OUT1_READY = 1;
        #1;
        check("drain_01", 16'(OUT1_DATA), 16'h01);
        tick();
        check("drain_02", 16'(OUT1_DATA), 16'h02);
        check("drain_v1", 16'(OUT1_VALID), 16'h1);
        check("04_gone", 16'(OUT2_VALID), 16'h0);
        tick();
        check("drained_v1", 16'(OUT1_VALID), 16'h0);

        // one-entry lane with simultaneous push/pop and pointer wrap
        OUT1_READY = 0;
        IN_VALID = 1; IN_SELECT = 0; IN_DATA = 8'h77;
        tick();
        check("one_d1", 16'(OUT1_DATA), 16'h77);
        OUT1_READY = 1; IN_DATA = 8'h10;
        tick();
        check("pp_v1", 16'(OUT1_VALID), 16'h1);
        check("pp_d1", 16'(OUT1_DATA), 16'h10);
        check("pp_rdy", 16'(IN_READY), 16'h1);
        for (int i = 0; i < 20; i++) begin
            IN_DATA = 8'h20 + 8'(i);
            tick();
            check("wrap_d1", 16'(OUT1_DATA), 16'(8'h20 + 8'(i)));
            check("wrap_v1", 16'(OUT1_VALID), 16'h1);
        end
        IN_VALID = 0;
        tick();
        check("wrap_end_v1", 16'(OUT1_VALID), 16'h0);

        // lane 2 full, then asynchronous reset between edges
        OUT2_READY = 0;
        IN_VALID = 1; IN_SELECT = 1; IN_DATA = 8'hEE;
        tick();
        IN_DATA = 8'hFF;
        tick();
        IN_VALID = 0;
        #1;
        check("full2_rdy", 16'(IN_READY), 16'h0);
        check("full2_head", 16'(OUT2_DATA), 16'hEE);
        #1;
        RESET = 1;
        #1;
        check("arst_v2", 16'(OUT2_VALID), 16'h0);
        check("arst_d2", 16'(OUT2_DATA), 16'h00);
        @(negedge CLK);
        RESET = 0;
        tick();
        check("post_rst_v2", 16'(OUT2_VALID), 16'h0);
        check("post_rst_rdy", 16'(IN_READY), 16'h1);

`ifdef DEMUX_STATS_EN
        check("stall_rst", STALL_CNT, 16'h0);
        OUT1_READY = 0;
        IN_VALID = 1; IN_SELECT = 0; IN_DATA = 8'h55;
        tick();
        tick();
        check("stall_none", STALL_CNT, 16'h0);
        repeat (5) tick();
        check("stall_5", STALL_CNT, 16'd5);
        repeat (70000) @(posedge CLK);
        #1;
        check("stall_sat", STALL_CNT, 16'hFFFF);
        IN_VALID = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
